// File: rtl/div_seq_unit_if.sv
// Operand/result handshake and scan signals of the sequential divider.
// The operand source (master) drives Start, operands and scan controls;
// the divider (slave) returns status, results and scan data out.
interface div_seq_unit_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Test;
  logic             SDI;
  logic             SDO;

  modport master (
    output Start, Dividend, Divisor, Test, SDI,
    input  Busy, Done, DivByZero, Quotient, Remainder, SDO
  );

  modport slave (
    input  Start, Dividend, Divisor, Test, SDI,
    output Busy, Done, DivByZero, Quotient, Remainder, SDO
  );
endinterface

// File: rtl/div_seq_unit.sv
// Sequential restoring divider: unsigned WIDTH/WIDTH -> quotient, remainder.
// One quotient bit per clock, start/done handshake, divide-by-zero flag and
// a full-state scan chain (QReg -> Acc -> DivReg) for test access.
module div_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic          Clock,
  input  logic          nReset,
  div_seq_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic [WIDTH-1:0] qreg_q,  qreg_d;
  logic             dbz_q,   dbz_d;

  // Partial remainder shifted left with the next dividend bit brought in.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;

  // One restoring step: trial subtract of the divisor from the shifted remainder.
  always_comb begin
    trial     = {acc_q, qreg_q[WIDTH-1]};
    no_borrow = (trial >= {1'b0, div_q});
    diff      = trial[WIDTH-1:0] - div_q;
  end

  // Next state: scan shift in test mode, otherwise the divide controller.
  always_comb begin
    // NOTE: every target gets a hold-value default first so no path through
    // the case below leaves a variable unassigned (which would infer a latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    div_d   = div_q;
    qreg_d  = qreg_q;
    dbz_d   = dbz_q;

    if (bus.Test) begin
      // Controller frozen; datapath registers form one 3*WIDTH shift chain.
      qreg_d = {qreg_q[WIDTH-2:0], bus.SDI};
      acc_d  = {acc_q[WIDTH-2:0],  qreg_q[WIDTH-1]};
      div_d  = {div_q[WIDTH-2:0],  acc_q[WIDTH-1]};
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) state_d = S_IDLE;
          if (bus.Start) begin
            if (bus.Divisor != '0) begin
              qreg_d  = bus.Dividend;
              acc_d   = '0;
              div_d   = bus.Divisor;
              cnt_d   = CNT_W'(WIDTH);
              dbz_d   = 1'b0;
              state_d = S_CALC;
            end else begin
              // No iteration: report all-ones quotient, dividend as remainder.
              qreg_d  = '1;
              acc_d   = bus.Dividend;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_CALC: begin
          if (no_borrow) begin
            acc_d  = diff;
            qreg_d = {qreg_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = trial[WIDTH-1:0];
            qreg_d = {qreg_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!nReset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      qreg_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      qreg_q  <= qreg_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Busy      = (state_q == S_CALC);
  assign bus.Done      = (state_q == S_DONE);
  assign bus.DivByZero = dbz_q;
  assign bus.Quotient  = qreg_q;
  assign bus.Remainder = acc_q;
  assign bus.SDO       = div_q[WIDTH-1];

endmodule
